muldiv_iter: RTL and testbench



---
 rtl/muldiv_iter.sv | 213 +++++++++++++++++++++
 tb/tb_muldiv_iter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider
// sharing one accumulator pair, with optional single-cycle early-out for trivial operands.
module muldiv_iter #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          EARLY_OUT = 1'b1
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iStart,
    input  logic [2:0]       iFunct3,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iFlush,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oResult
);

    localparam int unsigned      CNT_W   = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             start_c;
    logic             a_signed_c, b_signed_c;
    logic             a_neg_c, b_neg_c;
    logic [WIDTH-1:0] a_mag_c, b_mag_c;
    logic             early_c;
    logic [WIDTH-1:0] early_res_c;

    // Operand decode and trivial-case detection on the live inputs
    always_comb begin
        start_c     = (state_q == S_IDLE) && iStart && !iFlush;
        a_signed_c  = (iFunct3 == 3'b001) || (iFunct3 == 3'b010) ||
                      (iFunct3 == 3'b100) || (iFunct3 == 3'b110);
        b_signed_c  = (iFunct3 == 3'b001) || (iFunct3 == 3'b100) || (iFunct3 == 3'b110);
        a_neg_c     = a_signed_c && iA[WIDTH-1];
        b_neg_c     = b_signed_c && iB[WIDTH-1];
        a_mag_c     = a_neg_c ? -iA : iA;
        b_mag_c     = b_neg_c ? -iB : iB;
        early_c     = 1'b0;
        early_res_c = '0;
        if (EARLY_OUT) begin
            if (!iFunct3[2]) begin
                early_c = (iA == '0) || (iB == '0);
            end else if (iB == '0) begin
                early_c     = 1'b1;
                early_res_c = iFunct3[1] ? iA : '1;
            end else if (!iFunct3[0] && (iA == MIN_NEG) && (iB == '1)) begin
                early_c     = 1'b1;
                early_res_c = iFunct3[1] ? '0 : iA;
            end
        end
    end

    logic [WIDTH:0]     mul_sum_c;
    logic [WIDTH:0]     div_shift_c;
    logic [WIDTH:0]     div_diff_c;
    logic [2*WIDTH-1:0] prod_raw_c, prod_c;
    logic [WIDTH-1:0]   quot_c, rem_c, fix_res_c;

    // One iteration step for each engine, plus sign fix-up and result select
    always_comb begin
        mul_sum_c   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift_c = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff_c  = div_shift_c - {1'b0, opnd_q};
        prod_raw_c  = {acc_hi_q, acc_lo_q};
        prod_c      = (sa_q ^ sb_q) ? -prod_raw_c : prod_raw_c;
        // a zero divisor leaves an all-ones magnitude that must not be sign-flipped
        quot_c      = dz_q ? '1 : ((sa_q ^ sb_q) ? -acc_lo_q : acc_lo_q);
        rem_c       = sa_q ? -acc_hi_q : acc_hi_q;
        case (funct3_q)
            3'b000:                 fix_res_c = prod_c[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_res_c = prod_c[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fix_res_c = quot_c;
            default:                fix_res_c = rem_c;
        endcase
    end

    // State register
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_c && !early_c) state_d = S_CALC;
            S_CALC:  if (cnt_q == '0) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (iFlush) begin
            state_d = S_IDLE;
        end
    end

    // Datapath and output next values
    always_comb begin
        funct3_d = funct3_q;
        opnd_d   = opnd_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        cnt_d    = cnt_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        dz_d     = dz_q;
        result_d = result_q;
        done_d   = 1'b0;
        busy_d   = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (start_c) begin
                    if (early_c) begin
                        result_d = early_res_c;
                        done_d   = 1'b1;
                    end else begin
                        funct3_d = iFunct3;
                        sa_d     = a_neg_c;
                        sb_d     = b_neg_c;
                        dz_d     = (iB == '0);
                        cnt_d    = CNT_W'(WIDTH - 1);
                        acc_hi_d = '0;
                        opnd_d   = iFunct3[2] ? b_mag_c : a_mag_c;
                        acc_lo_d = iFunct3[2] ? a_mag_c : b_mag_c;
                    end
                end
            end
            S_CALC: begin
                if (!iFlush) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                    if (funct3_q[2]) begin
                        if (!div_diff_c[WIDTH]) begin
                            acc_hi_d = div_diff_c[WIDTH-1:0];
                            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi_d = div_shift_c[WIDTH-1:0];
                            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi_d = mul_sum_c[WIDTH:1];
                        acc_lo_d = {mul_sum_c[0], acc_lo_q[WIDTH-1:1]};
                    end
                end
            end
            S_FIX: begin
                if (!iFlush) begin
                    result_d = fix_res_c;
                    done_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            funct3_q <= '0;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            funct3_q <= funct3_d;
            opnd_q   <= opnd_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            dz_q     <= dz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign oBusy   = busy_q;
    assign oDone   = done_q;
    assign oResult = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: directed vector table, flush/reset sequences and random sweeps
// on three instances (32-bit early-out, 32-bit full latency, 8-bit early-out).
module tb_muldiv_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start, flush;
    logic [2:0]  funct;
    logic [31:0] opa, opb;
    int          sel;

    logic        start0, start1, start2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [31:0] res0, res1;
    logic [7:0]  res2;

    assign start0 = start && (sel == 0);
    assign start1 = start && (sel == 1);
    assign start2 = start && (sel == 2);

    muldiv_iter #(.WIDTH(32), .EARLY_OUT(1'b1)) u_eo (
        .iCLK(clk), .iRST(rst_n), .iStart(start0), .iFunct3(funct), .iA(opa), .iB(opb),
        .iFlush(flush), .oBusy(busy0), .oDone(done0), .oResult(res0));

    muldiv_iter #(.WIDTH(32), .EARLY_OUT(1'b0)) u_full (
        .iCLK(clk), .iRST(rst_n), .iStart(start1), .iFunct3(funct), .iA(opa), .iB(opb),
        .iFlush(flush), .oBusy(busy1), .oDone(done1), .oResult(res1));

    muldiv_iter #(.WIDTH(8), .EARLY_OUT(1'b1)) u_w8 (
        .iCLK(clk), .iRST(rst_n), .iStart(start2), .iFunct3(funct), .iA(opa[7:0]), .iB(opb[7:0]),
        .iFlush(flush), .oBusy(busy2), .oDone(done2), .oResult(res2));

    logic        busy_m, done_m;
    logic [31:0] res_m;
    always_comb begin
        case (sel)
            0:       begin busy_m = busy0; done_m = done0; res_m = res0; end
            1:       begin busy_m = busy1; done_m = done1; res_m = res1; end
            default: begin busy_m = busy2; done_m = done2; res_m = {24'd0, res2}; end
        endcase
    end

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_exp [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Architectural reference: plain arithmetic on sign/zero-extended 64-bit values
    function automatic logic [31:0] ref_model(input int w, input logic [2:0] f,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mask, ua, ub, sa, sb, r;
        longint      qa, qb;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        sa   = ua[w-1] ? (ua | ~mask) : ua;
        sb   = ub[w-1] ? (ub | ~mask) : ub;
        qa   = longint'(sa);
        qb   = longint'(sb);
        case (f)
            3'b000:  r = sa * sb;
            3'b001:  r = (sa * sb) >> w;
            3'b010:  r = (sa * ub) >> w;
            3'b011:  r = (ua * ub) >> w;
            3'b100:  r = (ub == 64'd0) ? mask : 64'(qa / qb);
            3'b101:  r = (ub == 64'd0) ? mask : ua / ub;
            3'b110:  r = (ub == 64'd0) ? ua : 64'(qa % qb);
            default: r = (ub == 64'd0) ? ua : ua % ub;
        endcase
        r = r & mask;
        return r[31:0];
    endfunction

    function automatic bit is_early(input int w, input logic [2:0] f,
                                    input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mask, ua, ub;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        ua   = a & mask;
        ub   = b & mask;
        if (!f[2]) return (ua == 32'd0) || (ub == 32'd0);
        if (ub == 32'd0) return 1'b1;
        if (f == 3'b100 || f == 3'b110) return (ua == (32'd1 << (w - 1))) && (ub == mask);
        return 1'b0;
    endfunction

    // Start one op on instance s at the current time, return in its oDone cycle
    task automatic do_op(input int s, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                         input bit toggle, input string tag);
        int lat;
        bit busy_ok;
        sel   = s;
        start = 1'b1;
        funct = f;
        opa   = a;
        opb   = b;
        @(posedge clk); #1;
        start   = 1'b0;
        lat     = 1;
        busy_ok = 1'b1;
        while (!done_m && lat < 100) begin
            if (!busy_m) busy_ok = 1'b0;
            if (toggle) begin
                opa   = $urandom;
                opb   = $urandom;
                funct = 3'($urandom);
                start = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        if (busy_m) busy_ok = 1'b0;
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " result"}, res_m, exp);
        chk({tag, " busy"}, 32'(busy_ok), 32'd1);
        if (done_m) last_exp[s] = exp;
    endtask

    typedef struct {
        int          s;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vt [$];

    task automatic add(input int s, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
        vec_t v;
        v.s = s; v.f = f; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
        vt.push_back(v);
    endtask

    task automatic sweep(input int s, input int w, input bit eo, input int n);
        for (int i = 0; i < n; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b, exp;
            int          lat;
            f = 3'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'($urandom_range(0, 3));
                1:       begin a = 32'd1 << (w - 1); b = 32'hFFFF_FFFF; end
                2:       a = 32'd0;
                3:       b = 32'($urandom_range(1, 255));
                default: ;
            endcase
            exp = ref_model(w, f, a, b);
            lat = (eo && is_early(w, f, a, b)) ? 1 : w + 2;
            do_op(s, f, a, b, exp, lat, 1'b1,
                  $sformatf("sweep%0d f=%0d a=%h b=%h", s, f, a, b));
        end
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        funct = 3'd0;
        opa   = 32'd0;
        opb   = 32'd0;
        sel   = 0;
        for (int i = 0; i < 3; i++) last_exp[i] = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset eo outputs", {busy0, done0, 30'd0} | res0, 32'd0);
        chk("reset full outputs", {busy1, done1, 30'd0} | res1, 32'd0);
        chk("reset w8 outputs", {busy2, done2, 22'd0, res2}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        add(0, 3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        add(0, 3'b001, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
        add(0, 3'b011, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, 34);
        add(0, 3'b010, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, 34);
        add(0, 3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34);
        add(0, 3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34);
        add(0, 3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 34);
        add(0, 3'b111, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 34);
        add(0, 3'b100, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 1);
        add(0, 3'b110, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1);
        add(1, 3'b100, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 34);
        add(1, 3'b110, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 34);
        add(1, 3'b100, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 34);
        add(1, 3'b110, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 34);
        add(0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        add(0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        add(1, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
        add(1, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34);
        add(0, 3'b000, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 1);
        add(1, 3'b000, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 34);
        add(0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        add(2, 3'b000, 32'h0000_0007, 32'h0000_00FD, 32'h0000_00EB, 10);
        add(2, 3'b100, 32'h0000_00F9, 32'h0000_0002, 32'h0000_00FD, 10);
        add(2, 3'b111, 32'h0000_00F9, 32'h0000_0002, 32'h0000_0001, 10);

        for (int i = 0; i < vt.size(); i++) begin
            do_op(vt[i].s, vt[i].f, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat, 1'b0,
                  $sformatf("vec%0d", i));
        end

        // Flush mid-operation: busy drops, no done, result holds
        sel   = 0;
        start = 1'b1;
        funct = 3'b011;
        opa   = 32'hFFFF_FFFF;
        opb   = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush busy low", 32'(busy_m), 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done_m) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("flush no done", 32'(seen), 32'd0);
        chk("flush result hold", res_m, last_exp[0]);

        // Flush together with start in IDLE: start dropped
        start = 1'b1;
        flush = 1'b1;
        funct = 3'b000;
        opa   = 32'd3;
        opb   = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done_m || busy_m) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("flush+start dropped", 32'(seen), 32'd0);
        chk("flush+start result hold", res_m, last_exp[0]);

        // Asynchronous reset mid-operation
        start = 1'b1;
        funct = 3'b011;
        opa   = 32'hFFFF_FFFF;
        opb   = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("async reset busy", 32'(busy0), 32'd0);
        chk("async reset done", 32'(done0), 32'd0);
        chk("async reset result", res0, 32'd0);
        for (int i = 0; i < 3; i++) last_exp[i] = 32'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        sweep(0, 32, 1'b1, 30);
        sweep(1, 32, 1'b0, 12);
        sweep(2, 8, 1'b1, 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
